alu_arbiter: RTL and testbench



---
 rtl/alu_arb_pkg.sv | 28 ++
 rtl/rr_arb2.sv | 38 +++
 rtl/alu_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_alu_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared state type, ALU width and 74181 op encodings for alu_arbiter.
package alu_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      EXEC_LO = 2'b01,
      EXEC_HI = 2'b10,
      DONE    = 2'b11
   } arb_state_t;

   localparam int ALU_W = 16;

   localparam logic [3:0] OP_ADD_S    = 4'b1001;
   localparam logic       OP_ADD_M    = 1'b0;
   localparam logic       OP_ADD_CIL  = 1'b1;
   localparam logic [3:0] OP_SUB_S    = 4'b0110;
   localparam logic       OP_SUB_M    = 1'b0;
   localparam logic       OP_SUB_CIL  = 1'b0;
   localparam logic [3:0] OP_XOR_S    = 4'b0110;
   localparam logic       OP_XOR_M    = 1'b1;
   localparam logic [3:0] OP_PASS_A_S = 4'b1111;
   localparam logic       OP_PASS_A_M = 1'b1;

   function automatic logic [1:0] id_to_onehot(input logic id);
      return id ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: combinational grant, pointer advanced on update.
module rr_arb2 #(
   parameter bit RR_RESET_PTR = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       update,
   output logic       grant_valid,
   output logic       grant_id
);

   logic rr_ptr_r;

   // A lone request always wins; the pointer only breaks ties.
   always_comb begin
      grant_valid = 1'b0;
      grant_id    = 1'b0;
      case (req)
         2'b01:   begin grant_valid = 1'b1; grant_id = 1'b0;     end
         2'b10:   begin grant_valid = 1'b1; grant_id = 1'b1;     end
         2'b11:   begin grant_valid = 1'b1; grant_id = rr_ptr_r; end
         default: begin grant_valid = 1'b0; grant_id = 1'b0;     end
      endcase
   end

   // Hand priority to the other requester after every grant.
   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr_r <= RR_RESET_PTR;
      end else if (update) begin
         rr_ptr_r <= ~grant_id;
      end else begin
         rr_ptr_r <= rr_ptr_r;
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one 16-bit 74181-style ALU between two requesters; long ops take two chained passes.
// Optional saturating busy counter enabled by defining ALU_ARB_BUSY_STATS_EN.
module alu_arbiter
   import alu_arb_pkg::*;
#(
   parameter bit RR_RESET_PTR = 1'b0,
   parameter int STATS_W      = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [1:0]         req,
   input  logic [3:0]         op0_s,
   input  logic [3:0]         op1_s,
   input  logic               op0_m,
   input  logic               op1_m,
   input  logic               op0_cil,
   input  logic               op1_cil,
   input  logic               op0_long,
   input  logic               op1_long,
   input  logic [31:0]        op0_a,
   input  logic [31:0]        op0_b,
   input  logic [31:0]        op1_a,
   input  logic [31:0]        op1_b,
   output logic [1:0]         ack,
   output logic [31:0]        res,
   output logic               res_co,
   output logic               res_aeb,
   output logic [3:0]         alu_s,
   output logic               alu_m,
   output logic               alu_cil,
   output logic [ALU_W-1:0]   alu_a,
   output logic [ALU_W-1:0]   alu_b,
   input  logic [ALU_W-1:0]   alu_z,
   input  logic               alu_co,
   input  logic               alu_aeb,
   output logic [STATS_W-1:0] busy_count
);

   arb_state_t       state_r;
   logic             gid_r, long_r, carry_r, aeb_r;
   logic [ALU_W-1:0] a_hi_r, b_hi_r, res_lo_r;
   logic [1:0]       ack_r;
   logic [31:0]      res_r;
   logic             res_co_r, res_aeb_r;
   logic [3:0]       alu_s_r;
   logic             alu_m_r, alu_cil_r;
   logic [ALU_W-1:0] alu_a_r, alu_b_r;

   logic             gnt_valid_s, gnt_id_s, grant_s;
   logic [3:0]       sel_s_s;
   logic             sel_m_s, sel_cil_s, sel_long_s;
   logic [31:0]      sel_a_s, sel_b_s;

   assign grant_s = (state_r == IDLE) && gnt_valid_s;

   rr_arb2 #(.RR_RESET_PTR(RR_RESET_PTR)) u_rr (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .update      (grant_s),
      .grant_valid (gnt_valid_s),
      .grant_id    (gnt_id_s)
   );

   // Operand set of whichever requester the picker selects.
   always_comb begin
      sel_s_s    = op0_s;
      sel_m_s    = op0_m;
      sel_cil_s  = op0_cil;
      sel_long_s = op0_long;
      sel_a_s    = op0_a;
      sel_b_s    = op0_b;
      if (gnt_id_s) begin
         sel_s_s    = op1_s;
         sel_m_s    = op1_m;
         sel_cil_s  = op1_cil;
         sel_long_s = op1_long;
         sel_a_s    = op1_a;
         sel_b_s    = op1_b;
      end else begin
         sel_s_s    = op0_s;
         sel_m_s    = op0_m;
         sel_cil_s  = op0_cil;
         sel_long_s = op0_long;
         sel_a_s    = op0_a;
         sel_b_s    = op0_b;
      end
   end

   // Sequencer: grant, low pass, optional high pass, then a one-cycle ack.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= IDLE;
         gid_r     <= 1'b0;
         long_r    <= 1'b0;
         carry_r   <= 1'b1;
         aeb_r     <= 1'b0;
         a_hi_r    <= 16'h0000;
         b_hi_r    <= 16'h0000;
         res_lo_r  <= 16'h0000;
         ack_r     <= 2'b00;
         res_r     <= 32'h0000_0000;
         res_co_r  <= 1'b1;
         res_aeb_r <= 1'b0;
         alu_s_r   <= 4'b0000;
         alu_m_r   <= 1'b1;
         alu_cil_r <= 1'b1;
         alu_a_r   <= 16'h0000;
         alu_b_r   <= 16'h0000;
      end else begin
         case (state_r)
            IDLE: begin
               ack_r <= 2'b00;
               if (grant_s) begin
                  gid_r     <= gnt_id_s;
                  long_r    <= sel_long_s;
                  a_hi_r    <= sel_a_s[31:16];
                  b_hi_r    <= sel_b_s[31:16];
                  alu_s_r   <= sel_s_s;
                  alu_m_r   <= sel_m_s;
                  alu_cil_r <= sel_cil_s;
                  alu_a_r   <= sel_a_s[15:0];
                  alu_b_r   <= sel_b_s[15:0];
                  state_r   <= EXEC_LO;
               end else begin
                  state_r   <= IDLE;
               end
            end
            EXEC_LO: begin
               res_lo_r <= alu_z;
               carry_r  <= alu_co;
               aeb_r    <= alu_aeb;
               if (long_r) begin
                  // The low-pass carry is already active-low, so it chains straight in.
                  alu_cil_r <= alu_co;
                  alu_a_r   <= a_hi_r;
                  alu_b_r   <= b_hi_r;
                  state_r   <= EXEC_HI;
               end else begin
                  res_r     <= {16'h0000, alu_z};
                  res_co_r  <= alu_co;
                  res_aeb_r <= alu_aeb;
                  ack_r     <= id_to_onehot(gid_r);
                  state_r   <= DONE;
               end
            end
            EXEC_HI: begin
               carry_r   <= alu_co;
               aeb_r     <= aeb_r & alu_aeb;
               res_r     <= {alu_z, res_lo_r};
               res_co_r  <= alu_co;
               res_aeb_r <= aeb_r & alu_aeb;
               ack_r     <= id_to_onehot(gid_r);
               state_r   <= DONE;
            end
            DONE: begin
               ack_r   <= 2'b00;
               state_r <= IDLE;
            end
            default: begin
               ack_r   <= 2'b00;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign ack     = ack_r;
   assign res     = res_r;
   assign res_co  = res_co_r;
   assign res_aeb = res_aeb_r;
   assign alu_s   = alu_s_r;
   assign alu_m   = alu_m_r;
   assign alu_cil = alu_cil_r;
   assign alu_a   = alu_a_r;
   assign alu_b   = alu_b_r;

`ifdef ALU_ARB_BUSY_STATS_EN
   logic [STATS_W-1:0] busy_count_r;

   // Saturating count of cycles the ALU spends executing a pass.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy_count_r <= {STATS_W{1'b0}};
      end else if (((state_r == EXEC_LO) || (state_r == EXEC_HI)) &&
                   (busy_count_r != {STATS_W{1'b1}})) begin
         busy_count_r <= busy_count_r + {{(STATS_W-1){1'b0}}, 1'b1};
      end else begin
         busy_count_r <= busy_count_r;
      end
   end

   assign busy_count = busy_count_r;
`else
   assign busy_count = {STATS_W{1'b0}};
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural 74181 slice, transaction-level model compared every cycle,
// plus directed operations with hand-computed results.
module tb_alu_arbiter;
   import alu_arb_pkg::*;

   localparam int STATS_W = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0_b, req1_b;
   logic [1:0]  req;
   logic [3:0]  op0_s, op1_s;
   logic        op0_m, op1_m, op0_cil, op1_cil, op0_long, op1_long;
   logic [31:0] op0_a, op0_b, op1_a, op1_b;
   logic [1:0]  ack;
   logic [31:0] res;
   logic        res_co, res_aeb;
   logic [3:0]  alu_s;
   logic        alu_m, alu_cil;
   logic [15:0] alu_a, alu_b, alu_z;
   logic        alu_co, alu_aeb;
   logic [STATS_W-1:0] busy_count;

   assign req = {req1_b, req0_b};

   always #5 clk = ~clk;

   alu_arbiter #(.RR_RESET_PTR(1'b0), .STATS_W(STATS_W)) dut (
      .clk(clk), .reset(reset), .req(req),
      .op0_s(op0_s), .op1_s(op1_s), .op0_m(op0_m), .op1_m(op1_m),
      .op0_cil(op0_cil), .op1_cil(op1_cil), .op0_long(op0_long), .op1_long(op1_long),
      .op0_a(op0_a), .op0_b(op0_b), .op1_a(op1_a), .op1_b(op1_b),
      .ack(ack), .res(res), .res_co(res_co), .res_aeb(res_aeb),
      .alu_s(alu_s), .alu_m(alu_m), .alu_cil(alu_cil), .alu_a(alu_a), .alu_b(alu_b),
      .alu_z(alu_z), .alu_co(alu_co), .alu_aeb(alu_aeb), .busy_count(busy_count)
   );

   // 16-bit 74181 slice, active-high data, active-low carries; AEB modelled as a direct A==B compare.
   function automatic logic [17:0] alu181(input logic [3:0] s, input logic m, input logic cil,
                                          input logic [15:0] a, input logic [15:0] b);
      logic [15:0] f, x, y;
      logic [16:0] sum;
      logic        co;
      f = 16'h0000; x = 16'h0000; y = 16'h0000; co = 1'b1;
      if (m) begin
         case (s)
            4'd0: f = ~a;        4'd1: f = ~(a | b);  4'd2: f = ~a & b;     4'd3: f = 16'h0000;
            4'd4: f = ~(a & b);  4'd5: f = ~b;        4'd6: f = a ^ b;      4'd7: f = a & ~b;
            4'd8: f = ~a | b;    4'd9: f = ~(a ^ b);  4'd10: f = b;         4'd11: f = a & b;
            4'd12: f = 16'hFFFF; 4'd13: f = a | ~b;   4'd14: f = a | b;     default: f = a;
         endcase
      end else begin
         case (s)
            4'd0: begin x = a;      y = 16'h0000; end
            4'd1: begin x = a | b;  y = 16'h0000; end
            4'd2: begin x = a | ~b; y = 16'h0000; end
            4'd3: begin x = 16'h0000; y = 16'hFFFF; end
            4'd4: begin x = a;      y = a & ~b; end
            4'd5: begin x = a | b;  y = a & ~b; end
            4'd6: begin x = a;      y = ~b; end
            4'd7: begin x = a & ~b; y = 16'hFFFF; end
            4'd8: begin x = a;      y = a & b; end
            4'd9: begin x = a;      y = b; end
            4'd10: begin x = a | ~b; y = a & b; end
            4'd11: begin x = a & b;  y = 16'hFFFF; end
            4'd12: begin x = a;      y = a; end
            4'd13: begin x = a | b;  y = a; end
            4'd14: begin x = a | ~b; y = a; end
            default: begin x = a;    y = 16'hFFFF; end
         endcase
         sum = {1'b0, x} + {1'b0, y} + {16'h0000, ~cil};
         f   = sum[15:0];
         co  = ~sum[16];
      end
      return {co, (a == b), f};
   endfunction

   always_comb {alu_co, alu_aeb, alu_z} = alu181(alu_s, alu_m, alu_cil, alu_a, alu_b);

   // Whole-operation result {co, aeb, res}: one pass, or two with the low carry chained in.
   function automatic logic [33:0] ref_op(input logic [3:0] s, input logic m, input logic cil,
                                          input logic lng, input logic [31:0] a, input logic [31:0] b);
      logic [17:0] lo, hi;
      lo = alu181(s, m, cil, a[15:0], b[15:0]);
      if (!lng) return {lo[17], lo[16], 16'h0000, lo[15:0]};
      hi = alu181(s, m, lo[17], a[31:16], b[31:16]);
      return {hi[17], lo[16] & hi[16], hi[15:0], lo[15:0]};
   endfunction

   int total = 0;
   int bad   = 0;
   bit cmp_en = 1'b0;
   int ack_order[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction model: counts edges to the ack, one idle cycle after each DONE.
   logic [1:0]  exp_ack;
   logic [31:0] exp_res;
   logic        exp_co, exp_aeb;
   logic [STATS_W-1:0] exp_busy;
   int          m_left;
   bit          m_cool, m_ptr, m_gid;
   logic [33:0] m_pend;
   logic        pick_s;

   always_comb pick_s = (req == 2'b11) ? m_ptr : req[1];

   always @(posedge clk) begin
      if (reset) begin
         exp_ack <= 2'b00; exp_res <= 32'h0; exp_co <= 1'b1; exp_aeb <= 1'b0;
         exp_busy <= '0; m_left <= 0; m_cool <= 1'b0; m_ptr <= 1'b0; m_gid <= 1'b0;
      end else if (m_left > 0) begin
`ifdef ALU_ARB_BUSY_STATS_EN
         if (exp_busy != {STATS_W{1'b1}}) exp_busy <= exp_busy + 1'b1;
`endif
         m_left <= m_left - 1;
         if (m_left == 1) begin
            exp_ack <= m_gid ? 2'b10 : 2'b01;
            {exp_co, exp_aeb, exp_res} <= m_pend;
            m_cool <= 1'b1;
         end else begin
            exp_ack <= 2'b00;
         end
      end else if (m_cool) begin
         m_cool  <= 1'b0;
         exp_ack <= 2'b00;
      end else begin
         exp_ack <= 2'b00;
         if (req != 2'b00) begin
            m_gid  <= pick_s;
            m_ptr  <= ~pick_s;
            m_pend <= pick_s ? ref_op(op1_s, op1_m, op1_cil, op1_long, op1_a, op1_b)
                             : ref_op(op0_s, op0_m, op0_cil, op0_long, op0_a, op0_b);
            m_left <= (pick_s ? op1_long : op0_long) ? 2 : 1;
         end
      end
   end

   // Compare outputs to the model every cycle, away from the active edge.
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("ack", 32'(ack), 32'(exp_ack));
         chk("res", res, exp_res);
         chk("res_co", 32'(res_co), 32'(exp_co));
         chk("res_aeb", 32'(res_aeb), 32'(exp_aeb));
         chk("busy_count", 32'(busy_count), 32'(exp_busy));
      end
   end

   task automatic run_op(input int id, input logic [3:0] s, input logic m, input logic cil,
                         input logic lng, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] xres, input logic xco, input logic xaeb,
                         input int xlat, input bit scramble);
      int n;
      @(posedge clk); #1;
      if (id == 0) begin
         op0_s = s; op0_m = m; op0_cil = cil; op0_long = lng; op0_a = a; op0_b = b; req0_b = 1'b1;
      end else begin
         op1_s = s; op1_m = m; op1_cil = cil; op1_long = lng; op1_a = a; op1_b = b; req1_b = 1'b1;
      end
      @(negedge clk);
      n = 0;
      while (!ack[id] && n < 40) begin
         @(negedge clk);
         n++;
         if (scramble && n == 1) begin
            if (id == 0) begin op0_a = ~op0_a; op0_b = 32'hDEAD_BEEF; op0_cil = ~op0_cil; end
            else         begin op1_a = ~op1_a; op1_b = 32'hDEAD_BEEF; op1_cil = ~op1_cil; end
         end
      end
      chk("ack_seen", 32'(ack[id]), 32'd1);
      if (ack[id]) begin
         ack_order.push_back(id);
         if (xlat >= 0) chk("latency", n, xlat);
         chk("lit_res", res, xres);
         chk("lit_co", 32'(res_co), 32'(xco));
         chk("lit_aeb", 32'(res_aeb), 32'(xaeb));
      end
      @(posedge clk); #1;
      if (id == 0) req0_b = 1'b0; else req1_b = 1'b0;
   endtask

   initial begin
      reset = 1'b1; req0_b = 1'b0; req1_b = 1'b0;
      op0_s = 4'h0; op1_s = 4'h0; op0_m = 1'b0; op1_m = 1'b0; op0_cil = 1'b1; op1_cil = 1'b1;
      op0_long = 1'b0; op1_long = 1'b0; op0_a = 32'h0; op0_b = 32'h0; op1_a = 32'h0; op1_b = 32'h0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      cmp_en = 1'b1;
      @(negedge clk);
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_res", res, 32'h0);
      chk("rst_co", 32'(res_co), 32'd1);
      chk("rst_aeb", 32'(res_aeb), 32'd0);
      chk("rst_alu_s", 32'(alu_s), 32'd0);
      chk("rst_alu_m", 32'(alu_m), 32'd1);
      chk("rst_alu_cil", 32'(alu_cil), 32'd1);
      chk("rst_alu_ab", {alu_a, alu_b}, 32'h0);

      run_op(0, OP_ADD_S, OP_ADD_M, OP_ADD_CIL, 1'b0, 32'h0000_1234, 32'h0000_0001,
             32'h0000_1235, 1'b1, 1'b0, 2, 1'b0);
      run_op(0, OP_ADD_S, OP_ADD_M, OP_ADD_CIL, 1'b1, 32'h0000_FFFF, 32'h0000_0001,
             32'h0001_0000, 1'b1, 1'b0, 3, 1'b1);
`ifdef ALU_ARB_BUSY_STATS_EN
      chk("busy_after_two", 32'(busy_count), 32'd3);
`else
      chk("busy_after_two", 32'(busy_count), 32'd0);
`endif
      run_op(1, OP_SUB_S, OP_SUB_M, OP_SUB_CIL, 1'b1, 32'h0005_0005, 32'h0005_0005,
             32'h0000_0000, 1'b0, 1'b1, 3, 1'b0);
      run_op(1, OP_SUB_S, OP_SUB_M, OP_SUB_CIL, 1'b1, 32'h0006_0005, 32'h0005_0005,
             32'h0001_0000, 1'b0, 1'b0, 3, 1'b0);
      run_op(0, OP_XOR_S, OP_XOR_M, 1'b1, 1'b0, 32'h0000_00F0, 32'h0000_0FF0,
             32'h0000_0F00, 1'b1, 1'b0, 2, 1'b0);
      run_op(1, OP_PASS_A_S, OP_PASS_A_M, 1'b1, 1'b0, 32'h5555_ABCD, 32'h1111_2222,
             32'h0000_ABCD, 1'b1, 1'b0, 2, 1'b0);

      // Reset arriving while the high pass is on the ALU drops the op.
      @(posedge clk); #1;
      op0_s = OP_ADD_S; op0_m = OP_ADD_M; op0_cil = OP_ADD_CIL; op0_long = 1'b1;
      op0_a = 32'h1234_0001; op0_b = 32'h0000_0002; req0_b = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("hi_pass_a", 32'(alu_a), 32'h0000_1234);
      #4 reset = 1'b1; req0_b = 1'b0;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("midrst_ack", 32'(ack), 32'd0);
      chk("midrst_res", res, 32'h0);
      chk("midrst_busy", 32'(busy_count), 32'd0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("no_late_ack", 32'(ack), 32'd0);
      end

      ack_order.delete();
      fork
         begin
            run_op(0, OP_ADD_S, OP_ADD_M, OP_ADD_CIL, 1'b0, 32'h0000_0100, 32'h0000_0023,
                   32'h0000_0123, 1'b1, 1'b0, -1, 1'b0);
            @(posedge clk);
            run_op(0, OP_ADD_S, OP_ADD_M, OP_ADD_CIL, 1'b0, 32'h0000_7FFF, 32'h0000_0001,
                   32'h0000_8000, 1'b1, 1'b0, -1, 1'b0);
         end
         begin
            run_op(1, OP_ADD_S, OP_ADD_M, OP_ADD_CIL, 1'b0, 32'h0000_0010, 32'h0000_0020,
                   32'h0000_0030, 1'b1, 1'b0, -1, 1'b0);
            @(posedge clk);
            run_op(1, OP_ADD_S, OP_ADD_M, OP_ADD_CIL, 1'b0, 32'h0000_FFFF, 32'h0000_FFFF,
                   32'h0000_FFFE, 1'b0, 1'b1, -1, 1'b0);
         end
      join
      chk("order_len", 32'(ack_order.size()), 32'd4);
      if (ack_order.size() == 4) begin
         chk("order0", 32'(ack_order[0]), 32'd0);
         chk("order1", 32'(ack_order[1]), 32'd1);
         chk("order2", 32'(ack_order[2]), 32'd0);
         chk("order3", 32'(ack_order[3]), 32'd1);
      end

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
